// File: rtl/memoria_pkg.sv
// Purpose : shared constants for the memoria_param slice (default geometry, FSM encoding).
// Latency : n/a (package only).
// Backpressure: n/a.
//
// Contents: ANCHO_DATO_DEF / ANCHO_DIR_DEF default word and address widths,
//           estado_t FSM encoding (BORRANDO = clearing array, LISTO = serving),
//           profundidad() helper returning the word count for an address width.
package memoria_pkg;

    localparam int ANCHO_DATO_DEF = 12;
    localparam int ANCHO_DIR_DEF  = 9;

    // Two-state controller: sweep-clearing the array, or serving requests.
    typedef enum logic {
        BORRANDO = 1'b0,
        LISTO    = 1'b1
    } estado_t;

    function automatic int profundidad(input int ancho);
        return 1 << ancho;
    endfunction

endpackage

// File: rtl/memoria_if.sv
// Purpose : request/response bundle between a requester and memoria_param.
// Latency : n/a (wires only).
// Backpressure: requester holds peticion_valida until it sees peticion_lista on an edge.
//
// Signals: peticion_valida/peticion_lista handshake, leer_escribir_memoria (1=read,
//          0=write), direccion_memoria, dato_escribir_memoria, and the read return
//          dato_leer_memoria qualified by the one-cycle dato_valido pulse.
// Modports: master (requester side), slave (memory side).
interface memoria_if
    import memoria_pkg::*;
#(
    parameter int ANCHO_DATO = ANCHO_DATO_DEF,
    parameter int ANCHO_DIR  = ANCHO_DIR_DEF
);

    logic                  peticion_valida;
    logic                  peticion_lista;
    logic                  leer_escribir_memoria;
    logic [ANCHO_DIR-1:0]  direccion_memoria;
    logic [ANCHO_DATO-1:0] dato_escribir_memoria;
    logic [ANCHO_DATO-1:0] dato_leer_memoria;
    logic                  dato_valido;

    modport master (
        output peticion_valida,
        output leer_escribir_memoria,
        output direccion_memoria,
        output dato_escribir_memoria,
        input  peticion_lista,
        input  dato_leer_memoria,
        input  dato_valido
    );

    modport slave (
        input  peticion_valida,
        input  leer_escribir_memoria,
        input  direccion_memoria,
        input  dato_escribir_memoria,
        output peticion_lista,
        output dato_leer_memoria,
        output dato_valido
    );

endinterface

// File: rtl/memoria_nucleo.sv
// Purpose : single-port synchronous RAM, 2**ANCHO_DIR words of ANCHO_DATO bits, no reset.
// Latency : write lands at the enabled edge; read data appears 1 cycle after the enabled edge.
// Backpressure: none, accepts one access every cycle.
//
// Ports: clock; en_i access enable; we_i 1=write 0=read; dir_i word address;
//        dato_i write data; dato_o registered read data (holds between reads).
module memoria_nucleo
    import memoria_pkg::*;
#(
    parameter int ANCHO_DATO = ANCHO_DATO_DEF,
    parameter int ANCHO_DIR  = ANCHO_DIR_DEF
) (
    input  logic                  clock,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [ANCHO_DIR-1:0]  dir_i,
    input  logic [ANCHO_DATO-1:0] dato_i,
    output logic [ANCHO_DATO-1:0] dato_o
);

    localparam int PROFUNDIDAD = profundidad(ANCHO_DIR);

    logic [ANCHO_DATO-1:0] mem_q [PROFUNDIDAD];
    logic [ANCHO_DATO-1:0] dato_q;

    // No reset on purpose: the array maps onto plain RAM. The read register
    // only loads on a read so the last read value is held across writes/idles.
    always_ff @(posedge clock) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[dir_i] <= dato_i;
            end else begin
                dato_q <= mem_q[dir_i];
            end
        end
    end

    assign dato_o = dato_q;

endmodule

// File: rtl/memoria_param.sv
// Purpose : parameterised single-port memory with valid/ready requests and optional power-up clear.
// Latency : write commits at the accepting edge; read data + dato_valido 1 cycle after acceptance.
// Backpressure: peticion_lista=1 every cycle once LISTO; 0 while reset or while sweeping the array.
//
// Ports: clock (rising edge), reset (async, active low), bus (memoria_if.slave).
// Build option: define MEMORIA_BORRADO_EN to clear every word to 0 after reset
//               (BORRANDO sweep, one word per cycle) before serving requests.
module memoria_param
    import memoria_pkg::*;
#(
    parameter int ANCHO_DATO = ANCHO_DATO_DEF,
    parameter int ANCHO_DIR  = ANCHO_DIR_DEF
) (
    input  logic     clock,
    input  logic     reset,
    memoria_if.slave bus
);

`ifdef MEMORIA_BORRADO_EN
    localparam estado_t ESTADO_RESET = BORRANDO;
`else
    localparam estado_t ESTADO_RESET = LISTO;
`endif
    localparam logic                 LISTA_RESET = (ESTADO_RESET == LISTO);
    localparam logic [ANCHO_DIR-1:0] CUENTA_FIN  = '1;

    estado_t               estado_q;
    logic                  lista_q;
    logic                  valido_q;
    logic                  hay_dato_q;
    logic [ANCHO_DIR-1:0]  cuenta_q;
    logic [ANCHO_DIR-1:0]  cuenta_d;

    logic                  peticion_lista;
    logic                  acepta;
    logic                  lee;
    logic                  barriendo;

    logic                  mem_en;
    logic                  mem_we;
    logic [ANCHO_DIR-1:0]  mem_dir;
    logic [ANCHO_DATO-1:0] mem_dat;
    logic [ANCHO_DATO-1:0] mem_rd;

    // lista_q resets to 1 when no sweep is built in, so the block is ready in
    // the very first cycle after release; gating with reset keeps it 0 while
    // reset is held without waiting for a clock edge.
    assign peticion_lista = lista_q & reset;

    assign acepta    = bus.peticion_valida & peticion_lista;
    assign lee       = acepta & bus.leer_escribir_memoria;
    assign barriendo = (estado_q == BORRANDO);
    assign cuenta_d  = cuenta_q + 1'b1;

    // The sweep owns the RAM port while clearing; requests cannot be accepted
    // then because peticion_lista is low.
    assign mem_en  = barriendo | acepta;
    assign mem_we  = barriendo | (acepta & ~bus.leer_escribir_memoria);
    assign mem_dir = barriendo ? cuenta_q : bus.direccion_memoria;
    assign mem_dat = barriendo ? '0 : bus.dato_escribir_memoria;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= ESTADO_RESET;
            lista_q    <= LISTA_RESET;
            cuenta_q   <= '0;
            valido_q   <= 1'b0;
            hay_dato_q <= 1'b0;
        end else begin
            valido_q <= lee;
            if (lee) begin
                hay_dato_q <= 1'b1;
            end
            case (estado_q)
                BORRANDO: begin
                    // Counter stops at the top address instead of wrapping;
                    // ready rises in the cycle after the last word is cleared.
                    if (cuenta_q == CUENTA_FIN) begin
                        estado_q <= LISTO;
                        lista_q  <= 1'b1;
                    end else begin
                        cuenta_q <= cuenta_d;
                    end
                end
                LISTO: begin
                    lista_q <= 1'b1;
                end
            endcase
        end
    end

    memoria_nucleo #(
        .ANCHO_DATO (ANCHO_DATO),
        .ANCHO_DIR  (ANCHO_DIR)
    ) u_nucleo (
        .clock  (clock),
        .en_i   (mem_en),
        .we_i   (mem_we),
        .dir_i  (mem_dir),
        .dato_i (mem_dat),
        .dato_o (mem_rd)
    );

    // The RAM read register has no reset; until the first read since reset the
    // output is forced to 0 so reset always presents a clean data bus.
    assign bus.peticion_lista    = peticion_lista;
    assign bus.dato_valido       = valido_q;
    assign bus.dato_leer_memoria = hay_dato_q ? mem_rd : '0;

endmodule

// File: tb/tb_memoria_param.sv
// Purpose : self-checking bench for memoria_param (default 12x512 and a 16x16 instance).
// Latency : checks read data/valid one cycle after acceptance.
// Backpressure: checks peticion_lista during reset, sweep (when built) and service.
module tb_memoria_param;

    logic clock;
    logic reset;

    memoria_if #(.ANCHO_DATO(12), .ANCHO_DIR(9)) bus  ();
    memoria_if #(.ANCHO_DATO(16), .ANCHO_DIR(4)) bus2 ();

    memoria_param #(.ANCHO_DATO(12), .ANCHO_DIR(9)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    memoria_param #(.ANCHO_DATO(16), .ANCHO_DIR(4)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        v;
        logic        rd;
        logic [8:0]  dir;
        logic [11:0] dat;
        logic        exp_v;
        logic [11:0] exp_d;
    } vec_t;

    vec_t tabla [12];

    // Reference memory: word contents plus a flag for words with defined data.
    logic [11:0] mem_m   [512];
    bit          known_m [512];
    logic [11:0] exp_d;
    bit          exp_d_ok;
    logic        exp_v;

    logic        r_v;
    logic        r_rd;
    logic [8:0]  r_dir;
    logic [11:0] r_dat;
    logic        lista_tras_reset;

    task automatic chk(input string nombre, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nombre, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic rd, input logic [8:0] a, input logic [11:0] d);
        bus.peticion_valida       = v;
        bus.leer_escribir_memoria = rd;
        bus.direccion_memoria     = a;
        bus.dato_escribir_memoria = d;
    endtask

    task automatic drive2(input logic v, input logic rd, input logic [3:0] a, input logic [15:0] d);
        bus2.peticion_valida       = v;
        bus2.leer_escribir_memoria = rd;
        bus2.direccion_memoria     = a;
        bus2.dato_escribir_memoria = d;
    endtask

    // Counts edges after release until peticion_lista rises (bounded).
    task automatic medir_barrido(input string nombre, input int esperado);
        int n = 0;
        while (bus.peticion_lista !== 1'b1 && n < 2000) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk(nombre, 32'(n), 32'(esperado));
    endtask

    task automatic esperar_lista2();
        int n = 0;
        while (bus2.peticion_lista !== 1'b1 && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("lista2_timeout", 32'(bus2.peticion_lista), 32'd1);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 512; i++) begin
            mem_m[i]   = 12'h000;
            known_m[i] = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) begin
            known_m[i] = 1'b0;
            mem_m[i]   = 12'h000;
        end
        // v, rd, dir, dat, exp_v, exp_d
        tabla[0]  = '{1'b1, 1'b0, 9'd5,   12'hAAA, 1'b0, 12'h000};
        tabla[1]  = '{1'b1, 1'b1, 9'd5,   12'h000, 1'b1, 12'hAAA};
        tabla[2]  = '{1'b0, 1'b1, 9'd5,   12'h000, 1'b0, 12'hAAA};
        tabla[3]  = '{1'b1, 1'b0, 9'd52,  12'h005, 1'b0, 12'hAAA};
        tabla[4]  = '{1'b1, 1'b1, 9'd52,  12'h000, 1'b1, 12'h005};
        tabla[5]  = '{1'b1, 1'b0, 9'd511, 12'h123, 1'b0, 12'h005};
        tabla[6]  = '{1'b1, 1'b1, 9'd511, 12'h000, 1'b1, 12'h123};
        tabla[7]  = '{1'b1, 1'b0, 9'd0,   12'hFFF, 1'b0, 12'h123};
        tabla[8]  = '{1'b1, 1'b1, 9'd511, 12'h000, 1'b1, 12'h123};
        tabla[9]  = '{1'b1, 1'b0, 9'd0,   12'hFFF, 1'b0, 12'h123};
        tabla[10] = '{1'b1, 1'b1, 9'd0,   12'h000, 1'b1, 12'hFFF};
        tabla[11] = '{1'b0, 1'b0, 9'd5,   12'h777, 1'b0, 12'hFFF};

        drive(1'b0, 1'b0, 9'd0, 12'h000);
        drive2(1'b0, 1'b0, 4'd0, 16'h0000);

        // ---------------- reset state ----------------
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_lista",  32'(bus.peticion_lista),     32'd0);
        chk("rst_valido", 32'(bus.dato_valido),        32'd0);
        chk("rst_dato",   32'(bus.dato_leer_memoria),  32'd0);
        chk("rst_lista2", 32'(bus2.peticion_lista),    32'd0);
        chk("rst_dato2",  32'(bus2.dato_leer_memoria), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
`ifdef MEMORIA_BORRADO_EN
        chk("lista_release", 32'(bus.peticion_lista), 32'd0);
        medir_barrido("sweep_len", 512);
        // Abort a sweep at address 200 and expect a full restart.
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (200) @(posedge clock);
        #1;
        chk("lista_mid_sweep", 32'(bus.peticion_lista), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        medir_barrido("sweep_restart_len", 512);
        model_clear();
        @(negedge clock);
        drive(1'b1, 1'b1, 9'd0, 12'h000);
        @(posedge clock);
        #1;
        chk("sweep_rd0_v", 32'(bus.dato_valido),       32'd1);
        chk("sweep_rd0_d", 32'(bus.dato_leer_memoria), 32'h000);
        drive(1'b1, 1'b1, 9'd511, 12'h000);
        @(posedge clock);
        #1;
        chk("sweep_rd511_v", 32'(bus.dato_valido),       32'd1);
        chk("sweep_rd511_d", 32'(bus.dato_leer_memoria), 32'h000);
        drive(1'b0, 1'b0, 9'd0, 12'h000);
        @(posedge clock);
        #1;
`else
        chk("lista_release", 32'(bus.peticion_lista), 32'd1);
`endif

        // ---------------- directed table ----------------
        for (int i = 0; i < 12; i++) begin
            drive(tabla[i].v, tabla[i].rd, tabla[i].dir, tabla[i].dat);
            @(posedge clock);
            #1;
            chk($sformatf("tab%0d_valido", i), 32'(bus.dato_valido),       32'(tabla[i].exp_v));
            chk($sformatf("tab%0d_dato", i),   32'(bus.dato_leer_memoria), 32'(tabla[i].exp_d));
            chk($sformatf("tab%0d_lista", i),  32'(bus.peticion_lista),    32'd1);
            if (tabla[i].v && !tabla[i].rd) begin
                mem_m[tabla[i].dir]   = tabla[i].dat;
                known_m[tabla[i].dir] = 1'b1;
            end
        end
        exp_d    = 12'hFFF;
        exp_d_ok = 1'b1;

        // ---------------- randomized against the model ----------------
        for (int i = 0; i < 400; i++) begin
            r_v   = ($urandom_range(0, 3) != 0);
            r_rd  = 1'($urandom_range(0, 1));
            r_dir = ($urandom_range(0, 1) == 1) ? 9'($urandom_range(0, 7)) : 9'($urandom);
            if ($urandom_range(0, 7) == 0) r_dir = 9'd511;
            r_dat = 12'($urandom);
            drive(r_v, r_rd, r_dir, r_dat);
            @(posedge clock);
            exp_v = 1'b0;
            if (r_v) begin
                if (r_rd) begin
                    exp_v    = 1'b1;
                    exp_d_ok = known_m[r_dir];
                    exp_d    = mem_m[r_dir];
                end else begin
                    mem_m[r_dir]   = r_dat;
                    known_m[r_dir] = 1'b1;
                end
            end
            #1;
            chk("rnd_valido", 32'(bus.dato_valido),    32'(exp_v));
            chk("rnd_lista",  32'(bus.peticion_lista), 32'd1);
            if (exp_d_ok) begin
                chk("rnd_dato", 32'(bus.dato_leer_memoria), 32'(exp_d));
            end
        end

        // ---------------- reset in the middle of a read ----------------
        drive(1'b1, 1'b0, 9'd52, 12'h005);
        @(posedge clock);
        drive(1'b1, 1'b1, 9'd52, 12'h000);
        @(posedge clock);
        #1;
        chk("midrd_valido_before", 32'(bus.dato_valido),       32'd1);
        chk("midrd_dato_before",   32'(bus.dato_leer_memoria), 32'h005);
        #1;
        reset = 1'b0;
        #1;
        chk("midrd_valido_abort", 32'(bus.dato_valido),       32'd0);
        chk("midrd_dato_abort",   32'(bus.dato_leer_memoria), 32'h000);
        chk("midrd_lista_abort",  32'(bus.peticion_lista),    32'd0);
        drive(1'b0, 1'b0, 9'd0, 12'h000);
        @(negedge clock);
        reset = 1'b1;
        #1;
`ifdef MEMORIA_BORRADO_EN
        lista_tras_reset = 1'b0;
`else
        lista_tras_reset = 1'b1;
`endif
        chk("midrd_lista_release", 32'(bus.peticion_lista), 32'(lista_tras_reset));
        medir_barrido("midrd_ready", lista_tras_reset ? 0 : 512);
        @(negedge clock);
        drive(1'b1, 1'b1, 9'd52, 12'h000);
        @(posedge clock);
        #1;
        chk("midrd_reread_v", 32'(bus.dato_valido), 32'd1);
        // Array survives reset unless the sweep is built in.
        chk("midrd_reread_d", 32'(bus.dato_leer_memoria), lista_tras_reset ? 32'h005 : 32'h000);
        drive(1'b0, 1'b0, 9'd0, 12'h000);

        // ---------------- 16-bit x 16-word instance ----------------
        esperar_lista2();
        @(negedge clock);
        drive2(1'b1, 1'b0, 4'd15, 16'hBEEF);
        @(posedge clock);
        #1;
        chk("w16_valido_write", 32'(bus2.dato_valido), 32'd0);
        drive2(1'b1, 1'b0, 4'd0, 16'h1234);
        @(posedge clock);
        #1;
        drive2(1'b1, 1'b1, 4'd15, 16'h0000);
        @(posedge clock);
        #1;
        chk("w16_valido", 32'(bus2.dato_valido),       32'd1);
        chk("w16_dato",   32'(bus2.dato_leer_memoria), 32'hBEEF);
        drive2(1'b1, 1'b1, 4'd0, 16'h0000);
        @(posedge clock);
        #1;
        chk("w16_dato0", 32'(bus2.dato_leer_memoria), 32'h1234);
        drive2(1'b0, 1'b0, 4'd0, 16'h0000);
        @(posedge clock);
        #1;
        chk("w16_valido_idle", 32'(bus2.dato_valido),       32'd0);
        chk("w16_hold",        32'(bus2.dato_leer_memoria), 32'h1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
